// File: rtl/universal_shift_reg_pkg.sv
// universal_shift_reg_pkg: shared mode encoding and counter-width helper for universal_shift_reg.
package universal_shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHL  = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_LOAD = 2'b11
   } shift_mode_t;

   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/shift_word_counter.sv
// shift_word_counter: counts shifts modulo DW and pulses done for one cycle on each completed word.
module shift_word_counter
   import universal_shift_reg_pkg::*;
#(
   parameter int DW = 8,
   localparam int CW = cnt_width(DW)
) (
   input  logic          clk_50MHz_i,
   input  logic          rst_async_ha_i,
   input  logic          inc,
   input  logic          clr,
   input  logic          load_zero,
   output logic [CW-1:0] cnt,
   output logic          done
);

   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
      if (rst_async_ha_i) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr || load_zero) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (inc) begin
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
         done <= (cnt == LAST);
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: DW-bit shift left/right/load register with word counter.
// Define UNIVERSAL_SHIFT_REG_ROTATE_EN to add Rotate_i (shifts recirculate instead of taking the D pins).
module universal_shift_reg
   import universal_shift_reg_pkg::*;
#(
   parameter int DW = 8,
   localparam int CW = cnt_width(DW)
) (
   input  logic          clk_50MHz_i,
   input  logic          rst_async_ha_i,
   input  logic          Enable_i,
   input  logic          Clear_i,
   input  logic [1:0]    Mode_i,
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
   input  logic          Rotate_i,
`endif
   input  logic          D_right_i,
   input  logic          D_left_i,
   input  logic [DW-1:0] Parallel_i,
   output logic [DW-1:0] Q_o,
   output logic          Serial_msb_o,
   output logic          Serial_lsb_o,
   output logic [CW-1:0] Shift_cnt_o,
   output logic          Word_done_o
);

   shift_mode_t   mode;
   logic [DW-1:0] q, q_nxt;
   logic          fill_r, fill_l, shift, load;

   assign mode = shift_mode_t'(Mode_i);

`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
   assign fill_r = Rotate_i ? q[DW-1] : D_right_i;
   assign fill_l = Rotate_i ? q[0] : D_left_i;
`else
   assign fill_r = D_right_i;
   assign fill_l = D_left_i;
`endif

   assign shift = Enable_i && (mode == MODE_SHL || mode == MODE_SHR);
   assign load  = Enable_i && (mode == MODE_LOAD);

   always_comb begin
      q_nxt = (mode == MODE_SHL)  ? {q[DW-2:0], fill_r} :
              (mode == MODE_SHR)  ? {fill_l, q[DW-1:1]} :
              (mode == MODE_LOAD) ? Parallel_i : q;
   end

   always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
      if (rst_async_ha_i)
         q <= '0;
      else if (Clear_i)
         q <= '0;
      else if (Enable_i)
         q <= q_nxt;
   end

   shift_word_counter #(.DW(DW)) u_cnt (
      .clk_50MHz_i   (clk_50MHz_i),
      .rst_async_ha_i(rst_async_ha_i),
      .inc           (shift),
      .clr           (Clear_i),
      .load_zero     (load),
      .cnt           (Shift_cnt_o),
      .done          (Word_done_o)
   );

   assign Q_o          = q;
   assign Serial_msb_o = q[DW-1];
   assign Serial_lsb_o = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed and randomized checks of universal_shift_reg (DW=8) against an arithmetic model.
module tb_universal_shift_reg;

   localparam int DW = 8;
   localparam int CW = $clog2(DW + 1);

   logic          clk_50MHz_i = 1'b0;
   logic          rst_async_ha_i;
   logic          Enable_i, Clear_i, Rotate_i, D_right_i, D_left_i;
   logic [1:0]    Mode_i;
   logic [DW-1:0] Parallel_i, Q_o;
   logic          Serial_msb_o, Serial_lsb_o, Word_done_o;
   logic [CW-1:0] Shift_cnt_o;

   int errors = 0;
   int checks = 0;
   int m_q, m_cnt, m_done;

   always #10 clk_50MHz_i = ~clk_50MHz_i;

   universal_shift_reg #(.DW(DW)) dut (
      .clk_50MHz_i   (clk_50MHz_i),
      .rst_async_ha_i(rst_async_ha_i),
      .Enable_i      (Enable_i),
      .Clear_i       (Clear_i),
      .Mode_i        (Mode_i),
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      .Rotate_i      (Rotate_i),
`endif
      .D_right_i     (D_right_i),
      .D_left_i      (D_left_i),
      .Parallel_i    (Parallel_i),
      .Q_o           (Q_o),
      .Serial_msb_o  (Serial_msb_o),
      .Serial_lsb_o  (Serial_lsb_o),
      .Shift_cnt_o   (Shift_cnt_o),
      .Word_done_o   (Word_done_o)
   );

   // Apply one cycle of inputs, advance the model by the same operation, sample 1 time unit after the edge.
   task automatic drive(input logic en, input logic clr, input logic [1:0] mode, input logic dr,
                        input logic dl, input logic [7:0] par, input logic rot);
      bit use_rot;
      Enable_i = en; Clear_i = clr; Mode_i = mode; D_right_i = dr; D_left_i = dl;
      Parallel_i = par; Rotate_i = rot;
      use_rot = 1'b0;
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      use_rot = rot;
`endif
      @(posedge clk_50MHz_i);
      #1;
      if (clr) begin
         m_q = 0; m_cnt = 0; m_done = 0;
      end else if (en && (mode == 2'b01 || mode == 2'b10)) begin
         if (mode == 2'b01)
            m_q = ((m_q * 2) + (use_rot ? m_q / 128 : int'(dr))) % 256;
         else
            m_q = (m_q / 2) + 128 * (use_rot ? m_q % 2 : int'(dl));
         m_cnt = m_cnt + 1;
         m_done = (m_cnt == DW);
         if (m_cnt == DW) m_cnt = 0;
      end else if (en && mode == 2'b11) begin
         m_q = int'(par); m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
      end
   endtask

   task automatic test_reset;
      rst_async_ha_i = 1'b1;
      Enable_i = 0; Clear_i = 0; Mode_i = 0; D_right_i = 0; D_left_i = 0; Parallel_i = 0; Rotate_i = 0;
      #25;
      checks++;
      if (Q_o !== 8'h00 || Shift_cnt_o !== 0 || Word_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: q=%h cnt=%0d done=%b want q=00 cnt=0 done=0", Q_o, Shift_cnt_o, Word_done_o);
      end
      @(negedge clk_50MHz_i);
      rst_async_ha_i = 1'b0;
      m_q = 0; m_cnt = 0; m_done = 0;
   endtask

   task automatic test_reset_midword;
      for (int i = 0; i < 3; i++) drive(1, 0, 2'b01, 1, 0, 8'h00, 0);
      checks++;
      if (Q_o !== 8'h07 || Shift_cnt_o !== 3) begin
         errors++;
         $display("FAIL midword_pre: q=%h cnt=%0d want q=07 cnt=3", Q_o, Shift_cnt_o);
      end
      #5 rst_async_ha_i = 1'b1;
      #1;
      checks++;
      if (Q_o !== 8'h00 || Shift_cnt_o !== 0 || Word_done_o !== 1'b0) begin
         errors++;
         $display("FAIL midword_async_reset: q=%h cnt=%0d done=%b want all zero", Q_o, Shift_cnt_o, Word_done_o);
      end
      #1 rst_async_ha_i = 1'b0;
      m_q = 0; m_cnt = 0; m_done = 0;
      drive(1, 0, 2'b01, 1, 0, 8'h00, 0);
      checks++;
      if (Q_o !== 8'h01 || Shift_cnt_o !== 1) begin
         errors++;
         $display("FAIL first_edge_after_reset: q=%h cnt=%0d want q=01 cnt=1", Q_o, Shift_cnt_o);
      end
   endtask

   task automatic test_serialize;
      logic [7:0] word;
      word = 8'hA5;
      drive(1, 0, 2'b11, 0, 0, word, 0);
      for (int i = 7; i >= 0; i--) begin
         checks++;
         if (Serial_msb_o !== word[i] || Word_done_o !== 1'b0) begin
            errors++;
            $display("FAIL serialize_bit%0d: msb=%b done=%b want msb=%b done=0", i, Serial_msb_o, Word_done_o, word[i]);
         end
         drive(1, 0, 2'b01, 0, 0, 8'h00, 0);
      end
      checks++;
      if (Word_done_o !== 1'b1 || Q_o !== 8'h00 || Shift_cnt_o !== 0) begin
         errors++;
         $display("FAIL serialize_done: done=%b q=%h cnt=%0d want done=1 q=00 cnt=0", Word_done_o, Q_o, Shift_cnt_o);
      end
      drive(1, 0, 2'b00, 0, 0, 8'h00, 0);
      checks++;
      if (Word_done_o !== 1'b0) begin
         errors++;
         $display("FAIL serialize_pulse_width: done=%b want 0", Word_done_o);
      end
   endtask

   task automatic test_deserialize;
      logic [7:0] bits;
      int pulses;
      bits = 8'b1100_1010;
      pulses = 0;
      for (int i = 7; i >= 0; i--) begin
         drive(1, 0, 2'b10, 0, bits[i], 8'h00, 0);
         pulses += int'(Word_done_o);
      end
      checks++;
      if (Q_o !== 8'h53 || Word_done_o !== 1'b1 || pulses != 1) begin
         errors++;
         $display("FAIL deserialize_word: q=%h done=%b pulses=%0d want q=53 done=1 pulses=1", Q_o, Word_done_o, pulses);
      end
      drive(1, 0, 2'b00, 0, 0, 8'h00, 0);
      checks++;
      if (Word_done_o !== 1'b0 || Shift_cnt_o !== 0 || Q_o !== 8'h53) begin
         errors++;
         $display("FAIL deserialize_after: done=%b cnt=%0d q=%h want done=0 cnt=0 q=53", Word_done_o, Shift_cnt_o, Q_o);
      end
   endtask

   task automatic test_hold_enable;
      int bad;
      drive(1, 0, 2'b11, 0, 0, 8'h3C, 0);
      drive(1, 0, 2'b01, 0, 0, 8'h00, 0);
      drive(1, 0, 2'b10, 0, 0, 8'h00, 0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 5) drive(0, 0, 2'b01, 1, 1, 8'hFF, 0);
         else drive(1, 0, 2'b00, 1, 1, 8'hFF, 0);
         if (Q_o !== 8'h3C || Shift_cnt_o !== 2 || Word_done_o !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_enable: %0d bad cycles, last q=%h cnt=%0d done=%b want q=3C cnt=2 done=0",
                  bad, Q_o, Shift_cnt_o, Word_done_o);
      end
   endtask

   task automatic test_clear_load;
      drive(1, 0, 2'b11, 0, 0, 8'h12, 0);
      drive(1, 0, 2'b01, 1, 0, 8'h00, 0);
      drive(1, 1, 2'b11, 0, 0, 8'hFF, 0);
      checks++;
      if (Q_o !== 8'h00 || Shift_cnt_o !== 0 || Word_done_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_vs_load: q=%h cnt=%0d done=%b want q=00 cnt=0 done=0", Q_o, Shift_cnt_o, Word_done_o);
      end
      drive(1, 0, 2'b11, 0, 0, 8'hC3, 0);
      drive(0, 1, 2'b01, 1, 1, 8'h00, 0);
      checks++;
      if (Q_o !== 8'h00) begin
         errors++;
         $display("FAIL clear_disabled: q=%h want 00", Q_o);
      end
      for (int i = 0; i < 7; i++) drive(1, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 8'h00, 0);
      checks++;
      if (Shift_cnt_o !== 7 || Word_done_o !== 1'b0) begin
         errors++;
         $display("FAIL count_mixed_dir: cnt=%0d done=%b want cnt=7 done=0", Shift_cnt_o, Word_done_o);
      end
      drive(1, 0, 2'b11, 0, 0, 8'h5A, 0);
      checks++;
      if (Shift_cnt_o !== 0 || Word_done_o !== 1'b0 || Q_o !== 8'h5A) begin
         errors++;
         $display("FAIL load_at_cnt7: cnt=%0d done=%b q=%h want cnt=0 done=0 q=5A", Shift_cnt_o, Word_done_o, Q_o);
      end
   endtask

   task automatic test_random;
      int bad, last_done;
      bad = 0;
      last_done = 0;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
         if (Q_o !== 8'(m_q) || Serial_msb_o !== 1'(m_q / 128) || Serial_lsb_o !== 1'(m_q % 2) ||
             Shift_cnt_o !== CW'(m_cnt) || Word_done_o !== 1'(m_done) || (last_done == 1 && Word_done_o === 1'b1)) begin
            if (bad < 5)
               $display("FAIL random_step%0d: q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%0d",
                        i, Q_o, Shift_cnt_o, Word_done_o, m_q, m_cnt, m_done);
            bad++;
         end
         last_done = int'(Word_done_o);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL random_model: %0d mismatching cycles want 0", bad);
      end
   endtask

`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
   task automatic test_rotate;
      int pulses;
      drive(1, 0, 2'b11, 0, 0, 8'h81, 0);
      drive(1, 0, 2'b01, 0, 0, 8'h00, 1);
      checks++;
      if (Q_o !== 8'h03) begin
         errors++;
         $display("FAIL rotate_once: q=%h want 03", Q_o);
      end
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 2'b01, 0, 0, 8'h00, 1);
         pulses += int'(Word_done_o);
      end
      checks++;
      if (Q_o !== 8'h81 || pulses != 1 || Word_done_o !== 1'b1) begin
         errors++;
         $display("FAIL rotate_word: q=%h pulses=%0d done=%b want q=81 pulses=1 done=1", Q_o, pulses, Word_done_o);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_reset_midword;
      test_serialize;
      test_deserialize;
      test_hold_enable;
      test_clear_load;
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
      test_rotate;
`endif
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register with serial-in on both ends, parallel load, parallel and serial outputs, and a shift counter that flags each completed DW-bit word. It generalises the fixed-direction 4-bit serial register into one block usable as serializer, deserializer, or delay line in the serial-link datapath. An optional rotate feature is selected at compile time.

## Interface
- DW, default 8, register width in bits; legal range 2..64.
- CW, derived localparam, $clog2(DW+1); width of the shift counter.
- clk_50MHz_i  input  1  system clock; all state updates on its rising edge.
- rst_async_ha_i  input  1  reset, asynchronous and active-high.
- Enable_i  input  1  qualifies Mode_i; when low, the register holds.
- Clear_i  input  1  synchronous clear of the register and counter.
- Mode_i  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- D_right_i  input  1  serial input entering bit 0 on a shift left.
- D_left_i  input  1  serial input entering bit DW-1 on a shift right.
- Parallel_i  input  DW  data for parallel load.
- Q_o  output  DW  register contents.
- Serial_msb_o  output  1  Q_o[DW-1].
- Serial_lsb_o  output  1  Q_o[0].
- Shift_cnt_o  output  CW  number of shifts since the last load, clear, or word completion.
- Word_done_o  output  1  one-cycle pulse after DW shifts.

## Operation
- Priority order is rst_async_ha_i, then Clear_i, then Enable_i with Mode_i.
- Reset sets Q_o, Shift_cnt_o and Word_done_o to 0.
- Clear_i=1 zeroes Q_o and Shift_cnt_o and forces Word_done_o to 0 on the next edge, regardless of Enable_i and Mode_i.
- With Enable_i=0 or Mode_i=00, all state holds and Word_done_o is 0 next cycle.
- Shift left (01): Q <= {Q[DW-2:0], D_right_i}.
- Shift right (10): Q <= {D_left_i, Q[DW-1:1]}.
- Parallel load (11): Q <= Parallel_i; Shift_cnt_o <= 0; no done pulse.
- Counter:
  - Increments on each enabled shift in either direction.
  - When an enabled shift occurs with Shift_cnt_o == DW-1, the counter wraps to 0 and Word_done_o is 1 for the following cycle.
  - Changing direction mid-word does not reset the count.
- Word_done_o is otherwise 0 and never stays high for two consecutive cycles, except when back-to-back words complete (only possible when DW=1, which is illegal).
- Undefined Mode_i values cannot occur because the 2-bit encoding is fully decoded.

## Timing
- All outputs are registered or direct register taps, so there is no combinational input-to-output path.
- Q_o reflects an operation one edge after it is sampled.
- Serial latency: a bit applied on D_right_i under continuous shift-left appears on Serial_msb_o after exactly DW edges. The same holds for D_left_i to Serial_lsb_o under shift-right.
- Word_done_o rises on the same edge at which Q_o holds the complete DW-th shifted bit.
- Reset asserted mid-word takes effect asynchronously. The first edge after reset deassertion is a normal operating edge.

## Configuration
- UNIVERSAL_SHIFT_REG_ROTATE_EN defined:
  - Adds the input port Rotate_i (1 bit).
  - When Rotate_i=1, shift left takes Q[DW-1] into bit 0 and shift right takes Q[0] into bit DW-1, ignoring the D pins.
  - Rotates count toward Word_done_o like ordinary shifts.
- Undefined: the Rotate_i port is absent and shifts always take the D pins.

## Structure
- The shared package universal_shift_reg_pkg holds:
  - typedef shift_mode_t, a 2-bit enum: MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11.
  - The localparam function computing CW.
- One sub-module, shift_word_counter, holds the CW-bit counter and the done-pulse register. Its inputs are inc, clr and load-zero, with parameter DW.

## Test plan
- Reset mid-word: DW=8, Mode_i=01, D_right_i=1 for 3 edges, then assert rst_async_ha_i between edges. Q_o, Shift_cnt_o and Word_done_o must go to 0 immediately, without a clock edge.
- Serialize: load Parallel_i=8'hA5, then shift left 8 times with D_right_i=0. Serial_msb_o must read 1,0,1,0,0,1,0,1 before each shift edge, and Word_done_o must pulse once after the 8th shift with Q_o=8'h00.
- Deserialize: shift right 8 times with D_left_i = 1,1,0,0,1,0,1,0. Q_o must equal 8'h53, with Word_done_o high for exactly one cycle and Shift_cnt_o=0 afterwards.
- Hold and enable: with Q_o=8'h3C, apply Mode_i=01 and Enable_i=0 for 5 cycles, then Mode_i=00 with Enable_i=1. Q_o must stay 8'h3C, Shift_cnt_o must be unchanged, and no done pulse may occur.
- Simultaneous events: Clear_i=1 together with Mode_i=11 and Parallel_i=8'hFF. Q_o must be 8'h00, and Clear_i wins. Separately, a load at Shift_cnt_o=7 must zero the count with no pulse.
- Rotate (macro defined): load 8'h81, Rotate_i=1, shift left once. Q_o must become 8'h03, and after 8 rotates Q_o must return to 8'h81 with one Word_done_o pulse.
